// File: rtl/sw_input_pkg.sv
// Shared definitions for the switch-input producer: FSM state encoding and
// the default debounce length so the top level and its benches agree.
package sw_input_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } sw_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_CNT_WIDTH       = 20;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser for signals arriving
// asynchronously to clk; both stages reset to zero.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sw_input.sv
// Debounced switch-input producer: each debounced commit press latches one
// switch word and offers it to the CPU input port over valid/ready.
module sw_input
    import sw_input_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             commit_raw,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("sw_input: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0]     sw_s;
    logic                 commit_s;
    logic                 commit_prev_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    sw_state_e            state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 changed;
    logic                 stable;

    sync2 #(.WIDTH(WIDTH)) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sw_raw),
        .q_o   (sw_s)
    );

    sync2 #(.WIDTH(1)) u_sync_commit (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (commit_raw),
        .q_o   (commit_s)
    );

    assign changed = (commit_s != commit_prev_q);
    assign stable  = !changed && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (commit_s) state_d = PRESS;
            end
            PRESS: begin
                if (!commit_s) begin
                    state_d = IDLE;
                end else if (stable) begin
                    state_d = HOLD;
                    data_d  = sw_s;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (ready) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                end
            end
            RELEASE: begin
                // A re-press only clears the counter; no path back to HOLD.
                if (!commit_s && stable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (changed || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            commit_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            commit_prev_q <= commit_s;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sw_input.sv
// Directed bench for sw_input with a short debounce window; each task drives
// one scenario and checks its outputs against hand-computed values.
module tb_sw_input;

    localparam int WIDTH = 4;
    localparam int DB    = 8;
    localparam int LAT   = 2 + DB + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] sw_raw;
    logic             commit_raw;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             busy;

    int checks;
    int errors;

    sw_input #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DB),
        .CNT_WIDTH       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .commit_raw (commit_raw),
        .ready      (ready),
        .data       (data),
        .valid      (valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [WIDTH-1:0] got,
                              input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Press from a quiet IDLE and confirm the word appears exactly LAT edges later.
    task automatic press_and_expect(input string name, input logic [WIDTH-1:0] sw,
                                    input logic [WIDTH-1:0] exp);
        sw_raw     = sw;
        commit_raw = 1'b1;
        tick(LAT - 1);
        check_bit({name, "_valid_early"}, valid, 1'b0);
        tick(1);
        check_bit({name, "_valid_rise"}, valid, 1'b1);
        check_word({name, "_data"}, data, exp);
    endtask

    task automatic accept(input string name);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_bit({name, "_valid_fall"}, valid, 1'b0);
    endtask

    task automatic release_to_idle(input string name);
        int t;
        commit_raw = 1'b0;
        t = 0;
        while (busy && t < 4 * LAT) begin
            tick(1);
            t++;
        end
        check_bit({name, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        sw_raw     = '0;
        commit_raw = 1'b0;
        ready      = 1'b0;
        tick(3);
        check_word("reset_data", data, '0);
        check_bit("reset_valid", valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(3);
        check_bit("post_reset_valid", valid, 1'b0);
    endtask

    task automatic test_reset_mid_hold;
        int stray;
        press_and_expect("rhold", 4'hA, 4'hA);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check_word("rhold_async_data", data, '0);
        check_bit("rhold_async_valid", valid, 1'b0);
        check_bit("rhold_async_busy", busy, 1'b0);
        commit_raw = 1'b0;
        tick(2);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            tick(1);
            if (valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL rhold_no_word: got %0d valid cycles expected 0", stray);
        end
    endtask

    task automatic test_clean_press_and_accept;
        int drops, extras;
        ready = 1'b0;
        press_and_expect("clean", 4'h5, 4'h5);
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (valid !== 1'b1 || data !== 4'h5) drops++;
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("[TB] FAIL clean_hold: got %0d bad cycles expected 0", drops);
        end
        accept("clean");
        extras = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (valid !== 1'b0) extras++;
        end
        checks++;
        if (extras != 0) begin
            errors++;
            $display("[TB] FAIL held_commit_second_word: got %0d valid cycles expected 0", extras);
        end
        check_bit("held_commit_busy", busy, 1'b1);
        commit_raw = 1'b0;
        tick(LAT - 1);
        check_bit("release_busy_before", busy, 1'b1);
        tick(1);
        check_bit("release_busy_after", busy, 1'b0);
    endtask

    task automatic test_bounce;
        int seen;
        sw_raw = 4'h9;
        seen   = 0;
        for (int i = 0; i < 40; i++) begin
            commit_raw = ((i / 3) % 2 == 0);
            tick(1);
            if (valid !== 1'b0) seen++;
        end
        commit_raw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL bounce_valid: got %0d valid cycles expected 0", seen);
        end
        check_bit("bounce_busy", busy, 1'b0);
    endtask

    task automatic test_data_change;
        sw_raw     = 4'h3;
        commit_raw = 1'b1;
        tick(3 + 5);
        sw_raw = 4'hC;
        tick(LAT - 8 - 1);
        check_bit("dchg_valid_early", valid, 1'b0);
        tick(1);
        check_bit("dchg_valid", valid, 1'b1);
        check_word("dchg_data", data, 4'hC);
        sw_raw = 4'h1;
        tick(5);
        check_word("dchg_frozen", data, 4'hC);
        check_bit("dchg_valid_hold", valid, 1'b1);
        accept("dchg");
        release_to_idle("dchg");
    endtask

    task automatic test_back_to_back;
        int extras;
        press_and_expect("b2b1", 4'h1, 4'h1);
        accept("b2b1");
        commit_raw = 1'b0;
        tick(4);
        commit_raw = 1'b1;
        tick(3);
        commit_raw = 1'b0;
        extras = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            tick(1);
            if (valid !== 1'b0) extras++;
        end
        checks++;
        if (extras != 0) begin
            errors++;
            $display("[TB] FAIL b2b_repress_word: got %0d valid cycles expected 0", extras);
        end
        release_to_idle("b2b1");
        press_and_expect("b2b2", 4'h2, 4'h2);
        accept("b2b2");
        release_to_idle("b2b2");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_hold();
        test_clean_press_and_accept();
        test_bounce();
        test_data_change();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
